// File: rtl/hx8352_delay_timer.sv
// Delay timer for the HX8352 init/command sequencer, clocked at 1 MHz so one cycle is 1 us.
// A rising start edge loads a delay in us or ms units; done pulses once when it elapses.
module hx8352_delay_timer #(
  parameter int CNT_W     = 16,
  parameter int MS_DIV    = 1000,
  parameter int PRE_W     = 10,
  parameter int RETRIGGER = 0
) (
  input  logic             clk_1MHz,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             unit_ms,
  input  logic [CNT_W-1:0] delay_val,
  output logic             busy,
  output logic             done,
  output logic             ready,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_FINISH
  } state_t;

  state_t             r_state;
  logic               r_start_q;
  logic               r_unit;
  logic               r_busy;
  logic [CNT_W-1:0]   r_rem;
  logic [PRE_W-1:0]   r_pre;

  state_t             w_state_next;
  logic               w_unit_next;
  logic               w_busy_next;
  logic [CNT_W-1:0]   w_rem_next;
  logic [PRE_W-1:0]   w_pre_next;
  logic               w_rise;
  logic               w_tick;
  logic               w_load;

  assign w_rise = start & ~r_start_q;
  // In us mode every cycle is a unit; in ms mode the prescaler marks the unit boundary.
  assign w_tick = ~r_unit | (r_pre == PRE_W'(MS_DIV - 1));

  always_comb begin
    w_state_next = r_state;
    w_unit_next  = r_unit;
    w_busy_next  = r_busy;
    w_rem_next   = r_rem;
    w_pre_next   = r_pre;
    w_load       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_load = w_rise;
      end
      S_FINISH: begin
        w_state_next = S_IDLE;
        w_load       = w_rise;
      end
      S_COUNT: begin
        if ((RETRIGGER != 0) && w_rise) begin
          w_load = 1'b1;
        end else if (w_tick) begin
          w_pre_next = '0;
          if (r_rem != '0) begin
            w_rem_next = r_rem - CNT_W'(1);
          end
          if (r_rem <= CNT_W'(1)) begin
            w_busy_next  = 1'b0;
            w_state_next = S_FINISH;
          end
        end else begin
          w_pre_next = r_pre + PRE_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_busy_next  = 1'b0;
        w_rem_next   = '0;
        w_pre_next   = '0;
      end
    endcase

    if (w_load) begin
      w_unit_next = unit_ms;
      w_pre_next  = '0;
      if (delay_val == '0) begin
        w_rem_next   = '0;
        w_busy_next  = 1'b0;
        w_state_next = S_FINISH;
      end else begin
        w_rem_next   = delay_val;
        w_busy_next  = 1'b1;
        w_state_next = S_COUNT;
      end
    end

    // Abort outranks everything, including a start edge in the same cycle.
    if (abort) begin
      w_state_next = S_IDLE;
      w_busy_next  = 1'b0;
      w_rem_next   = '0;
      w_pre_next   = '0;
    end
  end

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      r_unit    <= 1'b0;
      r_busy    <= 1'b0;
      r_rem     <= '0;
      r_pre     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_start_q <= start;
      r_unit    <= w_unit_next;
      r_busy    <= w_busy_next;
      r_rem     <= w_rem_next;
      r_pre     <= w_pre_next;
    end
  end

  assign busy      = r_busy;
  assign ready     = ~r_busy;
  assign done      = (r_state == S_FINISH);
  assign remaining = r_rem;

endmodule
